// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: serial FSM states and block-count helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int num_blocks(input int width, input int block_size);
        return width / block_size;
    endfunction

    // A one-block design would still need a one-bit counter to be legal.
    function automatic int cnt_width(input int width, input int block_size);
        int n;
        n = num_blocks(width, block_size);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_BLOCK_SIZE = 4;
    localparam int DEF_CNT_W      = cnt_width(DEF_WIDTH, DEF_BLOCK_SIZE);

endpackage

// File: rtl/block_sub_slice.sv
// Combinational BLOCK_SIZE-bit subtractor slice: diff = a - b - bin with lookahead borrow.
module block_sub_slice #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  bin,
    output logic [BLOCK_SIZE-1:0] diff,
    output logic                  bout
);

    logic [BLOCK_SIZE-1:0] gen;
    logic [BLOCK_SIZE-1:0] prop;
    logic [BLOCK_SIZE:0]   carry;
    logic                  cin;

    // Subtraction as a + ~b + ~bin; the carry out of that sum is the inverse of the borrow.
    assign gen  = a & ~b;
    assign prop = a ^ ~b;
    assign cin  = ~bin;

    // NOTE: every variable written in always_comb gets a value on every path
    // before it is read, otherwise synthesis infers a latch.
    always_comb begin
        logic term;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            carry[i+1] = gen[i];
            term       = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (term & gen[j]);
                term       = term & prop[j];
            end
            carry[i+1] = carry[i+1] | (term & cin);
        end
    end

    assign diff = prop ^ carry[BLOCK_SIZE-1:0];
    assign bout = ~carry[BLOCK_SIZE];

endmodule

// File: rtl/block_serial_subtractor.sv
// Serial subtractor: Diff = A - B - Bin, one BLOCK_SIZE slice per clock, LSB first.
// Define BLOCK_SUB_SATURATE_EN to clamp Diff to zero on unsigned underflow.
module block_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
);

    localparam int NUM_BLOCKS = num_blocks(WIDTH, BLOCK_SIZE);
    localparam int CNT_W      = cnt_width(WIDTH, BLOCK_SIZE);

    if ((WIDTH % BLOCK_SIZE) != 0 || NUM_BLOCKS < 2) begin : g_bad_params
        $error("block_serial_subtractor: WIDTH must be a multiple of BLOCK_SIZE with at least two blocks");
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  borrow_q;
    logic [WIDTH-1:0]      a_q, b_q;
    logic [BLOCK_SIZE-1:0] res_q [NUM_BLOCKS];

    logic [BLOCK_SIZE-1:0] a_slices [NUM_BLOCKS];
    logic [BLOCK_SIZE-1:0] b_slices [NUM_BLOCKS];
    logic [BLOCK_SIZE-1:0] slice_diff;
    logic                  slice_bout;
    logic                  accept, last_slice;
    logic [WIDTH-1:0]      full_diff, final_diff;

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_slices
        assign a_slices[k] = a_q[k*BLOCK_SIZE +: BLOCK_SIZE];
        assign b_slices[k] = b_q[k*BLOCK_SIZE +: BLOCK_SIZE];
    end

    block_sub_slice #(.BLOCK_SIZE(BLOCK_SIZE)) u_slice (
        .a    (a_slices[cnt_q]),
        .b    (b_slices[cnt_q]),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign accept     = in_valid && in_ready;
    assign last_slice = (state_q == BUSY) && (cnt_q == CNT_W'(NUM_BLOCKS - 1));

    // The top slice is still combinational on the last BUSY cycle; merge it in directly.
    always_comb begin
        full_diff = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            full_diff[k*BLOCK_SIZE +: BLOCK_SIZE] = res_q[k];
        end
        full_diff[WIDTH-1 -: BLOCK_SIZE] = slice_diff;
`ifdef BLOCK_SUB_SATURATE_EN
        final_diff = slice_bout ? '0 : full_diff;
`else
        final_diff = full_diff;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = BUSY;
            BUSY:    if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the slice store is small and fully reset so an aborted operation
    // can never leak stale bits into a later result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            for (int k = 0; k < NUM_BLOCKS; k++) res_q[k] <= '0;
            Diff     <= '0;
            Bout     <= 1'b0;
            Zero     <= 1'b0;
        end else if (accept) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            res_q[cnt_q] <= slice_diff;
            borrow_q     <= slice_bout;
            cnt_q        <= cnt_q + 1'b1;
            if (last_slice) begin
                Diff <= final_diff;
                Bout <= slice_bout;
                Zero <= (final_diff == '0);
            end
        end
    end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Randomized self-checking bench for block_serial_subtractor against an arithmetic model.
module tb_block_serial_subtractor;

    localparam int WIDTH = 32;
    localparam int BS    = 4;
    localparam int NB    = WIDTH / BS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             in_ready, out_valid, bout, zero;
    logic [WIDTH-1:0] diff;

    int n_checks = 0;
    int n_errors = 0;

    block_serial_subtractor #(.WIDTH(WIDTH), .BLOCK_SIZE(BS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (diff),
        .Bout      (bout),
        .Zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Model: {zero, bout, diff} from plain wide unsigned arithmetic.
    function automatic logic [WIDTH+1:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic bi);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] d;
        logic             bo;
        r  = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
        bo = (x < ({1'b0, y} + bi)) ? 1'b1 : 1'b0;
        d  = r[WIDTH-1:0];
`ifdef BLOCK_SUB_SATURATE_EN
        if (bo) d = '0;
`endif
        return {(d == '0), bo, d};
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = x;
        b = y;
        bin = bi;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic bi);
        logic [WIDTH+1:0] e;
        e = ref_sub(x, y, bi);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_diff"}, diff, e[WIDTH-1:0]);
        check({tag, "_bout"}, bout, e[WIDTH]);
        check({tag, "_zero"}, zero, e[WIDTH+1]);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic bi);
        int lat;
        start_op(x, y, bi);
        wait_result(lat);
        check({tag, "_latency"}, lat, NB);
        check_result(tag, x, y, bi);
        consume();
    endtask

    initial begin
        logic [WIDTH+1:0] e;
        int lat;

        // Reset state, observed while rst_n is still low.
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_zero", zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("small",     32'h0000_000A, 32'h0000_0003, 1'b0);
        do_op("underflow", 32'h0000_0000, 32'h0000_0001, 1'b0);
        do_op("ripple",    32'h1000_0000, 32'h0000_0000, 1'b1);
        do_op("equal",     32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        do_op("max_a",     32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        do_op("max_b_bin", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op("eq_bin",    32'h1234_5678, 32'h1234_5677, 1'b1);

        // Backpressure: results hold, in_ready stays low, a stray in_valid is dropped.
        start_op(32'h8000_0001, 32'h0000_0002, 1'b0);
        wait_result(lat);
        check("bp_latency", lat, NB);
        e = ref_sub(32'h8000_0001, 32'h0000_0002, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_diff", diff, e[WIDTH-1:0]);
            check("bp_bout", bout, e[WIDTH]);
            in_valid = (i == 2);
            a = 32'h5555_5555;
            b = 32'h1111_1111;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_diff_after_pulse", diff, e[WIDTH-1:0]);
        consume();
        do_op("bp_next", 32'h0000_0100, 32'h0000_0001, 1'b0);

        // Reset in the middle of slice 3 aborts cleanly.
        start_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        check("midrst_zero", zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 32'h0000_0010, 32'h0000_0010, 1'b0);

        // Randomized operations with random consumer delay.
        for (int n = 0; n < 25; n++) begin
            logic [WIDTH-1:0] x, y;
            logic             bi;
            int               d;
            x  = $urandom;
            y  = (n % 5 == 0) ? x : $urandom;
            bi = 1'($urandom_range(0, 1));
            start_op(x, y, bi);
            wait_result(lat);
            check("rnd_latency", lat, NB);
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            check_result("rnd", x, y, bi);
            consume();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
